// File: rtl/tdc_bram_sched.sv
// Shares BRAM port B among the capture writer, clear engine and reader; every grant is registered, and rd_dout follows rd_gnt by RD_LATENCY+1 cycles.
// Captures are never stalled: a capture that loses its slot is dropped. Reads are forced in after STARVE_LIMIT denied cycles.
module tdc_bram_sched #(
  parameter int                ADDR_W       = 15,
  parameter int                ADDR_STEP    = 4,
  parameter logic [ADDR_W-1:0] ADDR_LAST    = 15'h7FFC,
  parameter int                STARVE_LIMIT = 4,
  parameter int                RD_LATENCY   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cap_req,
  input  logic [7:0]        cap_data,
  output logic              cap_gnt,
  output logic              cap_full,
  output logic              cap_ovf,
  output logic [ADDR_W-2:0] cap_count,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [31:0]       rd_dout,
  output logic              clkb,
  output logic              rstb,
  output logic              enb,
  output logic [3:0]        web,
  output logic [ADDR_W-1:0] addrb,
  output logic [31:0]       datab,
  input  logic [31:0]       rd_data
);

  typedef enum logic [1:0] {
    SERVE    = 2'd0,
    CLEAR    = 2'd1,
    CLR_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);
  localparam logic [3:0]        SLIM    = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-2:0] CNT_ONE = (ADDR_W-1)'(1);

  state_t                 state;
  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      clr_addr;
  logic [3:0]             starve;
  logic [RD_LATENCY-1:0]  rd_pipe;
  logic                   do_rd;
  logic                   do_cap;

  assign clkb = sys_clk;
  assign rstb = 1'b0;

  // Arbitration; only SERVE with no clear request may grant anything.
  always_comb begin
    do_rd  = 1'b0;
    do_cap = 1'b0;
    if (state == SERVE && !clr_start) begin
      if (rd_req && starve == SLIM)  do_rd  = 1'b1;
      else if (cap_req && !cap_full) do_cap = 1'b1;
      else if (rd_req)               do_rd  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      starve <= '0;
    end else if (!rd_req || do_rd) begin
      starve <= '0;
    end else if (starve != SLIM) begin
      starve <= starve + 4'd1;
    end
  end

  // Read return path runs independently of the FSM so in-flight reads survive a clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_pipe  <= '0;
      rd_valid <= 1'b0;
      rd_dout  <= '0;
    end else begin
      rd_pipe[0] <= rd_gnt;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      rd_valid <= rd_pipe[RD_LATENCY-1];
      if (rd_pipe[RD_LATENCY-1]) rd_dout <= rd_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= SERVE;
      enb       <= 1'b0;
      web       <= '0;
      addrb     <= '0;
      datab     <= '0;
      cap_gnt   <= 1'b0;
      rd_gnt    <= 1'b0;
      cap_full  <= 1'b0;
      cap_ovf   <= 1'b0;
      cap_count <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      wr_ptr    <= '0;
      clr_addr  <= '0;
    end else begin
      cap_gnt <= 1'b0;
      rd_gnt  <= 1'b0;
      enb     <= 1'b0;
      web     <= '0;
      case (state)
        SERVE: begin
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
          if (clr_start) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_busy <= 1'b1;
          end else begin
            if (cap_req && cap_full) cap_ovf <= 1'b1;
            if (do_rd) begin
              rd_gnt <= 1'b1;
              enb    <= 1'b1;
              addrb  <= rd_addr;
            end else if (do_cap) begin
              cap_gnt   <= 1'b1;
              enb       <= 1'b1;
              web       <= 4'hF;
              addrb     <= wr_ptr;
              datab     <= {24'b0, cap_data};
              cap_count <= cap_count + CNT_ONE;
              if (wr_ptr == ADDR_LAST) cap_full <= 1'b1;
              else                     wr_ptr   <= wr_ptr + STEP;
            end
          end
        end
        CLEAR: begin
          clr_busy <= 1'b1;
          enb      <= 1'b1;
          web      <= 4'hF;
          datab    <= '0;
          addrb    <= clr_addr;
          if (clr_addr == ADDR_LAST) begin
            state     <= CLR_DONE;
            wr_ptr    <= '0;
            cap_full  <= 1'b0;
            cap_ovf   <= 1'b0;
            cap_count <= '0;
          end else begin
            clr_addr <= clr_addr + STEP;
          end
        end
        CLR_DONE: begin
          clr_busy <= 1'b1;
          clr_done <= 1'b1;
          if (!clr_start) state <= SERVE;
        end
        default: state <= SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_bram_sched.sv
// Directed bench for tdc_bram_sched with a behavioural single-cycle-latency BRAM on port B.
module tb_tdc_bram_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cap_req;
  logic [7:0]  cap_data;
  logic        cap_gnt, cap_full, cap_ovf;
  logic [13:0] cap_count;
  logic        clr_start, clr_busy, clr_done;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic        rd_gnt, rd_valid;
  logic [31:0] rd_dout;
  logic        clkb, rstb, enb;
  logic [3:0]  web;
  logic [14:0] addrb;
  logic [31:0] datab;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;

  tdc_bram_sched dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cap_req(cap_req), .cap_data(cap_data), .cap_gnt(cap_gnt),
    .cap_full(cap_full), .cap_ovf(cap_ovf), .cap_count(cap_count),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_dout(rd_dout),
    .clkb(clkb), .rstb(rstb), .enb(enb), .web(web),
    .addrb(addrb), .datab(datab), .rd_data(rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  logic [31:0] mem [0:8191];
  logic [31:0] rd_q = 32'h0;
  assign rd_data = rd_q;
  always @(posedge clkb) begin
    if (enb) begin
      for (int b = 0; b < 4; b++)
        if (web[b]) mem[addrb[14:2]][b*8 +: 8] <= datab[b*8 +: 8];
      rd_q <= mem[addrb[14:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int bad;
    logic [7:0] vals [0:4];
    logic exp_rg, exp_rv;
    vals = '{8'h05, 8'h11, 8'h22, 8'h33, 8'hAB};

    sys_rst_n = 1'b0; cap_req = 1'b0; cap_data = 8'h00;
    clr_start = 1'b0; rd_req = 1'b0; rd_addr = '0;
    step(); step();
    chk("rst_enb",   32'(enb), 32'd0);
    chk("rst_web",   32'(web), 32'd0);
    chk("rst_addrb", 32'(addrb), 32'd0);
    chk("rst_count", 32'(cap_count), 32'd0);
    chk("rst_busy",  32'(clr_busy), 32'd0);
    chk("rst_rstb",  32'(rstb), 32'd0);
    sys_rst_n = 1'b1;
    step();
    chk("idle_enb", 32'(enb), 32'd0);

    // Fill the whole BRAM with captures.
    cap_req = 1'b1; cap_data = 8'h05;
    bad = 0;
    for (int i = 0; i < 8192; i++) begin
      step();
      if (cap_gnt !== 1'b1 || enb !== 1'b1 || web !== 4'hF || addrb !== 15'(i*4) ||
          datab !== 32'h5 || (i < 8191 && cap_full !== 1'b0)) bad++;
    end
    chk("fill_seq", 32'(bad), 32'd0);
    chk("fill_full", 32'(cap_full), 32'd1);
    chk("fill_count", 32'(cap_count), 32'd8192);
    step();
    chk("ovf_gnt", 32'(cap_gnt), 32'd0);
    chk("ovf_enb", 32'(enb), 32'd0);
    chk("ovf_flag", 32'(cap_ovf), 32'd1);

    // One-cycle clear pulse while captures are still requested.
    clr_start = 1'b1;
    step();
    chk("clr_entry_enb", 32'(enb), 32'd0);
    chk("clr_entry_busy", 32'(clr_busy), 32'd1);
    clr_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 8192; i++) begin
      step();
      if (enb !== 1'b1 || web !== 4'hF || datab !== 32'h0 || addrb !== 15'(i*4) ||
          cap_gnt !== 1'b0 || rd_gnt !== 1'b0 || clr_busy !== 1'b1 || clr_done !== 1'b0) bad++;
    end
    chk("clr_sweep", 32'(bad), 32'd0);
    chk("clr_count", 32'(cap_count), 32'd0);
    chk("clr_full", 32'(cap_full), 32'd0);
    chk("clr_ovf", 32'(cap_ovf), 32'd0);
    step();
    chk("clr_done_hi", 32'(clr_done), 32'd1);
    chk("clr_done_enb", 32'(enb), 32'd0);
    step();
    chk("clr_done_lo", 32'(clr_done), 32'd0);
    chk("clr_busy_lo", 32'(clr_busy), 32'd0);
    chk("post_clr_gnt", 32'(cap_gnt), 32'd1);
    chk("post_clr_addr", 32'(addrb), 32'd0);
    chk("post_clr_count", 32'(cap_count), 32'd1);

    bad = 0;
    for (int j = 1; j < 5; j++) begin
      cap_data = vals[j];
      step();
      if (cap_gnt !== 1'b1 || addrb !== 15'(j*4) || datab !== {24'b0, vals[j]}) bad++;
    end
    chk("cap_seq", 32'(bad), 32'd0);
    cap_req = 1'b0;
    step();
    chk("idle_hold_addr", 32'(addrb), 32'h10);
    chk("idle_hold_enb", 32'(enb), 32'd0);

    // Single read of the 0xAB word.
    rd_req = 1'b1; rd_addr = 15'h10;
    step();
    chk("rd_gnt", 32'(rd_gnt), 32'd1);
    chk("rd_web", 32'(web), 32'd0);
    chk("rd_addrb", 32'(addrb), 32'h10);
    rd_req = 1'b0;
    step();
    chk("rd_valid_t1", 32'(rd_valid), 32'd0);
    step();
    chk("rd_valid_t2", 32'(rd_valid), 32'd1);
    chk("rd_dout", rd_dout, 32'hAB);
    step();
    chk("rd_valid_t3", 32'(rd_valid), 32'd0);

    // Pipelined back-to-back reads.
    rd_req = 1'b1; rd_addr = 15'h4;
    step();
    chk("b2b_gnt0", 32'(rd_gnt), 32'd1);
    rd_addr = 15'h8;
    step();
    chk("b2b_gnt1", 32'(rd_gnt), 32'd1);
    rd_addr = 15'h7FFC;
    step();
    chk("b2b_v0", {31'b0, rd_valid} ^ rd_dout, 32'h10);
    rd_req = 1'b0;
    step();
    chk("b2b_d1", rd_dout, 32'h22);
    chk("b2b_v1", 32'(rd_valid), 32'd1);
    step();
    chk("b2b_d2", rd_dout, 32'h0);
    chk("b2b_v2", 32'(rd_valid), 32'd1);
    step();
    chk("b2b_end", 32'(rd_valid), 32'd0);

    // Capture vs read contention: one forced read every fifth slot.
    cap_req = 1'b1; rd_req = 1'b1; rd_addr = 15'h4;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_rg = (k % 5 == 0);
      exp_rv = (k >= 7) && ((k - 7) % 5 == 0);
      if (rd_gnt !== exp_rg || cap_gnt !== !exp_rg || rd_valid !== exp_rv ||
          (exp_rv && rd_dout !== 32'h11)) bad++;
    end
    chk("starve_pattern", 32'(bad), 32'd0);
    chk("starve_ovf", 32'(cap_ovf), 32'd0);
    chk("starve_count", 32'(cap_count), 32'd21);
    cap_req = 1'b0; rd_req = 1'b0;
    step(); step(); step();

    // Read in flight when a clear starts; reader starves through the clear.
    rd_req = 1'b1; rd_addr = 15'h8;
    step();
    chk("fl_gnt", 32'(rd_gnt), 32'd1);
    clr_start = 1'b1;
    step();
    chk("fl_entry_gnt", 32'(rd_gnt), 32'd0);
    chk("fl_entry_busy", 32'(clr_busy), 32'd1);
    clr_start = 1'b0;
    step();
    chk("fl_valid", 32'(rd_valid), 32'd1);
    chk("fl_dout", rd_dout, 32'h22);
    chk("fl_addr0", 32'(addrb), 32'd0);
    bad = 0;
    for (int i = 1; i < 8192; i++) begin
      step();
      if (rd_gnt !== 1'b0 || enb !== 1'b1 || addrb !== 15'(i*4) || rd_valid !== 1'b0) bad++;
    end
    chk("fl_sweep", 32'(bad), 32'd0);
    step();
    chk("fl_done", 32'(clr_done), 32'd1);
    chk("fl_done_gnt", 32'(rd_gnt), 32'd0);
    step();
    chk("fl_forced_gnt", 32'(rd_gnt), 32'd1);
    chk("fl_forced_addr", 32'(addrb), 32'h8);
    rd_req = 1'b0;
    step(); step();
    chk("fl_cleared_data", rd_dout, 32'h0);
    chk("fl_cleared_valid", 32'(rd_valid), 32'd1);

    // Reset with a read in flight discards its rd_valid.
    rd_req = 1'b1; rd_addr = 15'h4;
    step();
    rd_req = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk("rrst_gnt", 32'(rd_gnt), 32'd0);
    step();
    sys_rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (rd_valid !== 1'b0) bad++;
    end
    chk("rrst_flushed", 32'(bad), 32'd0);

    // Reset in the middle of a clear at address 0x1000.
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i <= 1024; i++) step();
    chk("mid_addr", 32'(addrb), 32'h1000);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_enb", 32'(enb), 32'd0);
    chk("mid_web", 32'(web), 32'd0);
    chk("mid_addrb", 32'(addrb), 32'd0);
    chk("mid_busy", 32'(clr_busy), 32'd0);
    step();
    sys_rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (enb !== 1'b0 || clr_busy !== 1'b0 || cap_gnt !== 1'b0 || rd_gnt !== 1'b0) bad++;
    end
    chk("mid_quiet", 32'(bad), 32'd0);
    cap_req = 1'b1; cap_data = 8'h07;
    step();
    chk("mid_cap_gnt", 32'(cap_gnt), 32'd1);
    chk("mid_cap_addr", 32'(addrb), 32'd0);
    chk("mid_cap_count", 32'(cap_count), 32'd1);
    cap_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdc_bram_sched.md
Name: tdc_bram_sched

Overview:
- Scheduler that shares the single BRAM port B between three requesters: the TDC capture writer, a bulk clear engine and a random-access reader (the Booth operand fetch path).
- Owns the BRAM write pointer, the full/overflow status and the clear sequence.
- Sits between the TDC front end / Booth datapath and the BRAM, and replaces ad-hoc direct port driving.

Parameters:
- ADDR_W, 15, BRAM byte-address width.
- ADDR_STEP, 4, byte increment per 32-bit word.
- ADDR_LAST, 15'h7FFC, last valid word address.
- STARVE_LIMIT, 4, consecutive denied read-request cycles before the reader is forced a slot; range 1..15.
- RD_LATENCY, 1, BRAM read latency in cycles; range 1..2.

Ports:
- sys_clk  in  1  sole clock; also drives clkb.
- sys_rst_n  in  1  asynchronous, active-low reset.
- cap_req  in  1  capture word available this cycle.
- cap_data  in  8  TDC ones count to store.
- cap_gnt  out  1  capture write issued this cycle.
- cap_full  out  1  last address written; further captures dropped.
- cap_ovf  out  1  sticky: a capture was dropped because cap_full was set.
- cap_count  out  ADDR_W-1  words captured since the last clear (0..8192).
- clr_start  in  1  level request to zero the whole BRAM.
- clr_busy  out  1  clear in progress or awaiting release.
- clr_done  out  1  clear finished; held until clr_start drops.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_W  read byte address, sampled when rd_gnt is high.
- rd_gnt  out  1  read issued this cycle.
- rd_valid  out  1  one-cycle pulse; rd_dout is valid.
- rd_dout  out  32  registered read data.
- clkb  out  1  equals sys_clk.
- rstb  out  1  tied 0.
- enb  out  1  BRAM enable.
- web  out  4  BRAM byte write enables.
- addrb  out  ADDR_W  BRAM address.
- datab  out  32  BRAM write data.
- rd_data  in  32  BRAM read data.

Behaviour:
- Reset values (asynchronous, sys_rst_n low):
  - State SERVE.
  - enb, web, addrb, datab, cap_gnt, rd_gnt, rd_valid, rd_dout all 0.
  - cap_full, cap_ovf, cap_count, clr_busy, clr_done all 0.
  - Write pointer and starve counter 0; read pipeline flushed.
- Output timing:
  - All outputs except clkb and rstb are registered.
  - cap_gnt and rd_gnt are high in the same cycle that enb/web/addrb/datab present that access.
- SERVE, decision made each cycle from the inputs. Priority order:
  1. clr_start: next state CLEAR; no grant this cycle.
  2. Forced read: rd_req high and starve count = STARVE_LIMIT, so read wins.
  3. Capture: cap_req high and cap_full low.
  4. Read: rd_req high.
  5. Idle: enb=0, web=0; addrb and datab hold.
- Capture access:
  - enb=1, web=4'hF, addrb=wr_ptr, datab={24'b0,cap_data}, cap_count+1.
  - If wr_ptr==ADDR_LAST: set cap_full; wr_ptr holds.
  - Otherwise wr_ptr advances by ADDR_STEP.
- cap_req with cap_full high: no write, no cap_gnt; set cap_ovf. cap_req must not be held waiting; a word denied for a read slot is lost, with no cap_ovf.
- Read access:
  - enb=1, web=0, addrb=rd_addr.
  - rd_gnt high in cycle T.
  - rd_valid high and rd_dout = rd_data in cycle T+RD_LATENCY+1.
  - Back-to-back reads are pipelined, one per cycle.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each cycle rd_req is high and the read is not granted.
  - Clears on a read grant or when rd_req is low.
- CLEAR:
  - clr_busy=1. Each cycle: enb=1, web=4'hF, datab=0.
  - addrb steps 0, 4, …, ADDR_LAST, so 8192 cycles at defaults; no grants are issued.
  - After writing ADDR_LAST, go to CLR_DONE with wr_ptr=0 and cap_full, cap_ovf, cap_count cleared.
  - A clr_start drop mid-clear is ignored; the clear always completes.
  - A read already in flight on entry still produces its rd_valid.
- CLR_DONE:
  - enb=0, web=0, clr_done=1, clr_busy=1.
  - When clr_start is low: clr_done=0, clr_busy=0, next state SERVE.
- Reset mid-clear or mid-read: immediate return to reset values; pending rd_valid is discarded.
- Unused state encodings: return to SERVE with enb=0.

Test Plan:
- Reset, then cap_req held high with cap_data=8'h05 for 8192 cycles → addrb 0..0x7FFC, datab=0x00000005, cap_full=1 after the last write, cap_count=8192; one more cap_req → no cap_gnt, cap_ovf=1.
- cap_req and rd_req both held high continuously → read granted exactly every STARVE_LIMIT+1 cycles (1 in 5 at default); rd_valid 2 cycles after each rd_gnt; cap_ovf stays 0.
- Write 0xAB at address 0x0010 via capture, then rd_req with rd_addr=0x0010 → rd_dout=0x000000AB with rd_valid exactly RD_LATENCY+1 cycles after rd_gnt.
- clr_start pulsed for 1 cycle while capture is active → full 8192-cycle zero sweep; clr_done asserts and drops the cycle after (clr_start already low); cap_count=0, cap_full=0; next cap_req writes address 0.
- sys_rst_n low for 1 cycle at clear address 0x1000 → all outputs 0 asynchronously; after release, state SERVE and no BRAM activity without requests.
- rd_gnt issued in the cycle before clr_start → rd_valid still delivered during CLEAR; no further grants until CLR_DONE exits.
